user_pad_mux: RTL and testbench



---
 rtl/user_pad_mux_pkg.sv | 29 ++
 rtl/user_pad_mux_sync.sv | 27 ++
 rtl/user_pad_mux.sv | 192 +++++++++++++++++++
 tb/tb_user_pad_mux.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pad_mux_pkg.sv
// Shared encodings for user_pad_mux: pad modes, register map offsets,
// CTRL bit positions and the commit FSM state type.
package user_pad_mux_pkg;

    localparam logic [1:0] MODE_INPUT  = 2'd0;
    localparam logic [1:0] MODE_OUTPUT = 2'd1;
    localparam logic [1:0] MODE_BIDIR  = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    localparam logic [11:0] CTRL_OFF    = 12'h000;
    localparam logic [11:0] PADCFG_BASE = 12'h100;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_BUSY_BIT   = 1;
    localparam int CTRL_ERR_BIT    = 2;
    localparam int PADCFG_MODE_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_APPLY   = 2'd2
    } commit_state_t;

    // Pads in these modes feed their sampled io_in back to a function channel.
    function automatic logic is_input_mode(input logic [1:0] mode);
        return (mode == MODE_INPUT) || (mode == MODE_BIDIR);
    endfunction

endpackage

// File: rtl/user_pad_mux_sync.sv
// Multi-bit flop synchroniser with async-reset stages; only compiled when
// USER_PAD_MUX_SYNC_EN is defined, since only that build instantiates it.
`ifdef USER_PAD_MUX_SYNC_EN
module user_pad_mux_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`endif

// File: rtl/user_pad_mux.sv
// Wishbone-programmable pad multiplexer with shadow/active pad configuration and a
// break-before-make commit. Define USER_PAD_MUX_SYNC_EN to synchronise io_in.
module user_pad_mux
    import user_pad_mux_pkg::*;
#(
    parameter int NPADS       = 38,
    parameter int NFUNC       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int QUIESCE_CYC = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NFUNC-1:0] func_out,
    input  logic [NFUNC-1:0] func_oe,
    output logic [NFUNC-1:0] func_in,
    input  logic [NPADS-1:0] io_in,
    output logic [NPADS-1:0] io_out,
    output logic [NPADS-1:0] io_oeb,
    output logic [1:0]       o_dbg_state
);

    localparam int FW = (NFUNC > 1) ? $clog2(NFUNC) : 1;
    localparam int QW = (QUIESCE_CYC > 1) ? $clog2(QUIESCE_CYC) : 1;
    localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;

    commit_state_t   r_state;
    logic [QW-1:0]   r_qcnt;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_err;
    logic [FW-1:0]   r_sh_func [NPADS];
    logic [1:0]      r_sh_mode [NPADS];
    logic [FW-1:0]   r_ac_func [NPADS];
    logic [1:0]      r_ac_mode [NPADS];

    logic            w_acc;
    logic            w_busy;
    logic            w_is_ctrl;
    logic            w_is_pad;
    logic            w_commit;
    logic [5:0]      w_idx;
    logic [IW-1:0]   w_pidx;
    logic [31:0]     w_rdata;
    logic [NPADS-1:0] w_pad_in;
    logic            w_unused;

    // A strobe held through its own ack cycle is not accepted a second time.
    assign w_acc     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_idx     = wbs_adr_i[7:2];
    assign w_pidx    = w_idx[IW-1:0];
    assign w_is_ctrl = (wbs_adr_i[11:0] == CTRL_OFF);
    assign w_is_pad  = (wbs_adr_i[11:8] == PADCFG_BASE[11:8]) && (wbs_adr_i[1:0] == 2'b00)
                       && (int'(w_idx) < NPADS);
    assign w_commit  = w_acc & wbs_we_i & w_is_ctrl & wbs_dat_i[CTRL_COMMIT_BIT] & ~w_busy;
    assign w_unused  = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign o_dbg_state = r_state;

    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl) begin
            w_rdata[CTRL_BUSY_BIT] = w_busy;
            w_rdata[CTRL_ERR_BIT]  = r_err;
        end else if (w_is_pad) begin
            w_rdata[FW-1:0]                          = r_sh_func[w_pidx];
            w_rdata[PADCFG_MODE_LSB+1:PADCFG_MODE_LSB] = r_sh_mode[w_pidx];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_err <= 1'b0;
            for (int p = 0; p < NPADS; p++) begin
                r_sh_func[p] <= '0;
                r_sh_mode[p] <= MODE_INPUT;
            end
        end else begin
            r_ack <= w_acc;
            r_dat <= '0;
            if (w_acc) begin
                if (!wbs_we_i) begin
                    r_dat <= w_rdata;
                end else if (w_is_ctrl) begin
                    if (wbs_dat_i[CTRL_ERR_BIT]) r_err <= 1'b0;
                end else if (w_is_pad) begin
                    // The shadow is frozen while a commit is in flight.
                    if (w_busy) begin
                        r_err <= 1'b1;
                    end else begin
                        if (wbs_sel_i[0]) r_sh_func[w_pidx] <= wbs_dat_i[FW-1:0];
                        if (wbs_sel_i[1]) r_sh_mode[w_pidx] <= wbs_dat_i[PADCFG_MODE_LSB+1:PADCFG_MODE_LSB];
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_qcnt  <= '0;
            for (int p = 0; p < NPADS; p++) begin
                r_ac_func[p] <= '0;
                r_ac_mode[p] <= MODE_INPUT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_commit) begin
                        r_state <= ST_QUIESCE;
                        r_qcnt  <= '0;
                    end
                end
                ST_QUIESCE: begin
                    if (r_qcnt == QW'(QUIESCE_CYC - 1)) r_state <= ST_APPLY;
                    else r_qcnt <= r_qcnt + QW'(1);
                end
                ST_APPLY: begin
                    for (int p = 0; p < NPADS; p++) begin
                        r_ac_func[p] <= r_sh_func[p];
                        r_ac_mode[p] <= r_sh_mode[p];
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pads about to change are released during QUIESCE; untouched pads keep driving.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int p = 0; p < NPADS; p++) begin
            if (!((r_state == ST_QUIESCE) &&
                  ((r_ac_func[p] != r_sh_func[p]) || (r_ac_mode[p] != r_sh_mode[p])))
                && (int'(r_ac_func[p]) < NFUNC)) begin
                case (r_ac_mode[p])
                    MODE_OUTPUT: begin
                        io_oeb[p] = 1'b0;
                        io_out[p] = func_out[r_ac_func[p]];
                    end
                    MODE_BIDIR: begin
                        io_oeb[p] = ~func_oe[r_ac_func[p]];
                        io_out[p] = func_out[r_ac_func[p]];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef USER_PAD_MUX_SYNC_EN
    user_pad_mux_sync #(
        .WIDTH  (NPADS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (io_in),
        .o_q   (w_pad_in)
    );
`else
    localparam int unused_sync_stages = SYNC_STAGES;
    assign w_pad_in = io_in;
`endif

    // Scanning from the top pad down lets the lowest-index match win.
    always_comb begin
        func_in = '0;
        for (int f = 0; f < NFUNC; f++) begin
            for (int p = NPADS - 1; p >= 0; p--) begin
                if (is_input_mode(r_ac_mode[p]) && (int'(r_ac_func[p]) == f))
                    func_in[f] = w_pad_in[p];
            end
        end
    end

endmodule

// File: tb/tb_user_pad_mux.sv
// Randomised scoreboard bench for user_pad_mux against a pad-table reference model.
`timescale 1ns/1ps
module tb_user_pad_mux;

    localparam int NPADS = 38;
    localparam int NFUNC = 16;
`ifdef USER_PAD_MUX_SYNC_EN
    localparam int IN_LAT = 2;
`else
    localparam int IN_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [NFUNC-1:0] func_out = '0, func_oe = '0, func_in;
    logic [NPADS-1:0] io_in = '0, io_out, io_oeb;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    user_pad_mux dut (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we), .wbs_sel_i (sel),
        .wbs_adr_i (adr), .wbs_dat_i (wdat), .wbs_ack_o (ack), .wbs_dat_o (rdat),
        .func_out (func_out), .func_oe (func_oe), .func_in (func_in),
        .io_in (io_in), .io_out (io_out), .io_oeb (io_oeb), .o_dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    // Reference pad table: modes 0 in, 1 out, 2 bidir, 3 off.
    logic [1:0] m_sh_mode [NPADS];
    logic [1:0] m_ac_mode [NPADS];
    logic [3:0] m_sh_func [NPADS];
    logic [3:0] m_ac_func [NPADS];
    logic       m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[32]) check("wb_rdata", {32'd0, rdat}, {32'd0, mon_e[31:0]});
            end
        end
    end

    task automatic model_reset();
        for (int p = 0; p < NPADS; p++) begin
            m_sh_mode[p] = 2'd0; m_sh_func[p] = 4'd0;
            m_ac_mode[p] = 2'd0; m_ac_func[p] = 4'd0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_apply();
        for (int p = 0; p < NPADS; p++) begin
            m_ac_mode[p] = m_sh_mode[p];
            m_ac_func[p] = m_sh_func[p];
        end
    endtask

    task automatic exp_pads(input logic quiesce, output logic [NPADS-1:0] eo, output logic [NPADS-1:0] eoeb);
        eo = '0;
        eoeb = '1;
        for (int p = 0; p < NPADS; p++) begin
            if (!(quiesce && (m_ac_mode[p] != m_sh_mode[p] || m_ac_func[p] != m_sh_func[p]))) begin
                if (m_ac_mode[p] == 2'd1) begin
                    eoeb[p] = 1'b0;
                    eo[p] = func_out[m_ac_func[p]];
                end else if (m_ac_mode[p] == 2'd2) begin
                    eoeb[p] = ~func_oe[m_ac_func[p]];
                    eo[p] = func_out[m_ac_func[p]];
                end
            end
        end
    endtask

    function automatic logic [NFUNC-1:0] exp_func_in();
        logic [NFUNC-1:0] r;
        logic found;
        r = '0;
        for (int f = 0; f < NFUNC; f++) begin
            found = 1'b0;
            for (int p = 0; p < NPADS; p++) begin
                if (!found && (m_ac_mode[p] == 2'd0 || m_ac_mode[p] == 2'd2) && int'(m_ac_func[p]) == f) begin
                    r[f] = io_in[p];
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic check_pads(input string tag, input logic quiesce);
        logic [NPADS-1:0] eo, eoeb;
        exp_pads(quiesce, eo, eoeb);
        check({tag, "_io_out"}, 64'(io_out), 64'(eo));
        check({tag, "_io_oeb"}, 64'(io_oeb), 64'(eoeb));
        check({tag, "_func_in"}, 64'(func_in), 64'(exp_func_in()));
    endtask

    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic chk, input logic [31:0] expd);
        exp_q.push_back({chk, expd});
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_cycle(1'b1, a, d, s, 1'b0, 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] expd);
        wb_cycle(1'b0, a, 32'd0, 4'hF, 1'b1, expd);
    endtask

    task automatic pad_write(input int p, input logic [1:0] mode, input logic [3:0] func, input logic [3:0] s);
        wb_write(32'h100 + 32'(4 * p), {22'd0, mode, 4'd0, func}, s);
        if (s[0]) m_sh_func[p] = func;
        if (s[1]) m_sh_mode[p] = mode;
    endtask

    task automatic pad_read(input int p);
        wb_read(32'h100 + 32'(4 * p), {22'd0, m_sh_mode[p], 4'd0, m_sh_func[p]});
    endtask

    task automatic ctrl_read(input logic busy);
        wb_read(32'h0, {29'd0, m_err, busy, 1'b0});
    endtask

    // COMMIT sampled at edge N; checks cycles N+1 .. N+4.
    task automatic commit_check(input string tag);
        exp_q.push_back(33'd0);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h0; wdat = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check_pads({tag, "_q1"}, 1'b1);
        @(posedge clk); #1;
        check_pads({tag, "_q2"}, 1'b1);
        @(posedge clk); #1;
        check_pads({tag, "_apply"}, 1'b0);
        @(posedge clk); #1;
        model_apply();
        check_pads({tag, "_new"}, 1'b0);
    endtask

    function automatic logic [31:0] unmapped_addr();
        case ($urandom_range(0, 2))
            0:       return 32'h004 + 32'(4 * $urandom_range(0, 62));
            1:       return 32'h100 + 32'(4 * $urandom_range(NPADS, 63));
            default: return 32'h200 + 32'(4 * $urandom_range(0, 895));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_func_in", 64'(func_in), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_rdat", 64'(rdat), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        ctrl_read(1'b0);
        pad_read(5);

        // Output route: pad 6 -> OUTPUT, FUNC 3.
        func_out = 16'h0008;
        pad_write(6, 2'd1, 4'd3, 4'h3);
        pad_read(6);
        commit_check("route");
        check("route_on_oeb6", 64'(io_oeb[6]), 64'd0);
        check("route_on_out6", 64'(io_out[6]), 64'd1);
        func_out[3] = 1'b0; #1;
        check("route_follow_out6", 64'(io_out[6]), 64'd0);

        // Pad 9 driving, then break-before-make on pad 6 with pad 9 untouched.
        func_out = 16'h0020;
        pad_write(9, 2'd1, 4'd5, 4'h3);
        commit_check("pad9");
        func_out = 16'h0038;
        pad_write(6, 2'd1, 4'd4, 4'h1);
        commit_check("bbm");
        func_out[4] = 1'b0; #1;
        check("bbm_follow_out6", 64'(io_out[6]), 64'd0);
        check("bbm_pad9_oeb", 64'(io_oeb[9]), 64'd0);

        // Input priority: pads 10 and 12 both feed FUNC 2.
        pad_write(10, 2'd0, 4'd2, 4'h3);
        pad_write(12, 2'd0, 4'd2, 4'h3);
        commit_check("prio_cfg");
        io_in = NPADS'({$urandom, $urandom});
        io_in[10] = 1'b0;
        io_in[12] = 1'b1;
        repeat (IN_LAT + 1) @(posedge clk);
        #1;
        check("prio_func_in2_low", 64'(func_in[2]), 64'd0);
        check_pads("prio", 1'b0);
        pad_write(10, 2'd3, 4'd2, 4'h2);
        commit_check("prio_off");
        check("prio_func_in2_high", 64'(func_in[2]), 64'd1);

        // Busy protection: PADCFG write during QUIESCE is discarded and sets ERR.
        wb_write(32'h0, 32'h1, 4'hF);
        wb_write(32'h100, 32'h0000_0109, 4'h3);
        m_err = 1'b1;
        model_apply();
        ctrl_read(1'b0);
        pad_read(0);
        wb_write(32'h0, 32'h1, 4'hF);
        ctrl_read(1'b1);
        model_apply();
        wb_write(32'h0, 32'h4, 4'hF);
        m_err = 1'b0;
        ctrl_read(1'b0);
        wb_write(32'h0, 32'h1, 4'hF);
        wb_write(32'h0, 32'h1, 4'hF);
        model_apply();
        ctrl_read(1'b0);
        check_pads("busy_end", 1'b0);

        // Reset in QUIESCE: everything returns to reset values at once.
        io_in = '0;
        func_out = '1;
        func_oe = '1;
        pad_write(6, 2'd2, 4'd7, 4'h3);
        #1;
        check("prerst_oeb9", 64'(io_oeb[9]), 64'd0);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h0; wdat = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_io_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
        check("midrst_io_out", 64'(io_out), 64'd0);
        check("midrst_func_in", 64'(func_in), 64'd0);
        check("midrst_ack", 64'(ack), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        ctrl_read(1'b0);
        pad_read(6);
        check_pads("postrst", 1'b0);

        // Randomised traffic against the pad table.
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 6))
                0: pad_write($urandom_range(0, NPADS - 1), 2'($urandom_range(0, 3)),
                             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                1: pad_read($urandom_range(0, NPADS - 1));
                2: commit_check("rnd_commit");
                3: begin
                    func_out = 16'($urandom);
                    func_oe  = 16'($urandom);
                    io_in    = NPADS'({$urandom, $urandom});
                    repeat (IN_LAT + 1) @(posedge clk);
                    #1;
                    check_pads("rnd_pads", 1'b0);
                end
                4: ctrl_read(1'b0);
                5: wb_write(unmapped_addr(), $urandom, 4'($urandom_range(0, 15)));
                default: wb_read(unmapped_addr(), 32'd0);
            endcase
        end
        commit_check("rnd_final");

        // Strobe held for three edges: acked on the first and third only.
        exp_q.push_back({1'b1, 29'd0, m_err, 2'b00});
        exp_q.push_back({1'b1, 29'd0, m_err, 2'b00});
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ack_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
